// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Two-port arbiter for the register file's single write port.
//                Port 0 has priority, port 1 has a starvation guard, writes
//                to R15 are discarded, and a hardware clear of R0-R14 can
//                be sequenced. All register-file-facing outputs are flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATAWIDTH    = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p0_valid,
  input  logic [3:0]           p0_addr,
  input  logic [DATAWIDTH-1:0] p0_data,
  output logic                 p0_ready,
  input  logic                 p1_valid,
  input  logic [3:0]           p1_addr,
  input  logic [DATAWIDTH-1:0] p1_data,
  output logic                 p1_ready,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 rf_we,
  output logic [3:0]           rf_a3,
  output logic [DATAWIDTH-1:0] rf_wd3,
  output logic                 drop_r15
);

  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);
  localparam logic [3:0] C_LAST_CLR     = 4'd14;
  localparam logic [3:0] C_PC_REG       = 4'd15;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                 state_q,      state_d;
  logic [3:0]             starve_cnt_q, starve_cnt_d;
  logic [3:0]             clr_cnt_q,    clr_cnt_d;
  logic                   rf_we_q,      rf_we_d;
  logic [3:0]             rf_a3_q,      rf_a3_d;
  logic [DATAWIDTH-1:0]   rf_wd3_q,     rf_wd3_d;
  logic                   drop_r15_q,   drop_r15_d;

  logic                   w_force1;
  logic                   w_p0_xfer;
  logic                   w_p1_xfer;
  logic [3:0]             w_addr;
  logic [DATAWIDTH-1:0]   w_data;

  assign w_force1 = (starve_cnt_q >= C_STARVE_LIMIT);

  // Next-state, handshake and register-file output computation
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    rf_we_d      = 1'b0;
    rf_a3_d      = rf_a3_q;
    rf_wd3_d     = rf_wd3_q;
    drop_r15_d   = 1'b0;
    p0_ready     = 1'b0;
    p1_ready     = 1'b0;
    w_p0_xfer    = 1'b0;
    w_p1_xfer    = 1'b0;
    w_addr       = p0_addr;
    w_data       = p0_data;

    case (state_q)
      S_IDLE: begin
        if (!clr_start) begin
          // Port 1 only wins when port 0 is absent or port 1 is starving
          p0_ready  = !(w_force1 && p1_valid);
          p1_ready  = !p0_valid || w_force1;
          w_p0_xfer = p0_valid && p0_ready;
          w_p1_xfer = p1_valid && p1_ready;
          if (w_p1_xfer) begin
            w_addr = p1_addr;
            w_data = p1_data;
          end
          if (w_p0_xfer || w_p1_xfer) begin
            if (w_addr == C_PC_REG) begin
              // R15 is fed from the PC; swallow the write and flag it
              drop_r15_d = 1'b1;
            end else begin
              rf_we_d  = 1'b1;
              rf_a3_d  = w_addr;
              rf_wd3_d = w_data;
            end
          end
        end else begin
          // Launch the clear: first zero-write appears in the next cycle
          state_d   = S_CLEAR;
          clr_cnt_d = 4'd0;
          rf_we_d   = 1'b1;
          rf_a3_d   = 4'd0;
          rf_wd3_d  = '0;
        end
        // Starvation counter tracks consecutive stalled port-1 cycles
        if (p1_valid && !w_p1_xfer) begin
          starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
        end else begin
          starve_cnt_d = 4'd0;
        end
      end
      S_CLEAR: begin
        // clr_start is ignored here; starvation counter stays frozen
        if (clr_cnt_q == C_LAST_CLR) begin
          state_d   = S_IDLE;
          clr_cnt_d = 4'd0;
        end else begin
          clr_cnt_d = clr_cnt_q + 4'd1;
          rf_we_d   = 1'b1;
          rf_a3_d   = clr_cnt_q + 4'd1;
          rf_wd3_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= 4'd0;
      clr_cnt_q    <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_a3_q      <= 4'd0;
      rf_wd3_q     <= '0;
      drop_r15_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_a3_q      <= rf_a3_d;
      rf_wd3_q     <= rf_wd3_d;
      drop_r15_q   <= drop_r15_d;
    end
  end

  assign clr_busy = (state_q == S_CLEAR);
  assign rf_we    = rf_we_q;
  assign rf_a3    = rf_a3_q;
  assign rf_wd3   = rf_wd3_q;
  assign drop_r15 = drop_r15_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Scoreboard bench for regfile_write_arbiter. A reference
//                model predicts handshakes and next-cycle register-file
//                outputs; a monitor pops predictions after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int DW    = 32;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          p0_valid = 1'b0, p1_valid = 1'b0, clr_start = 1'b0;
  logic [3:0]    p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_data = '0, p1_data = '0;
  logic          p0_ready, p1_ready, clr_busy, rf_we, drop_r15;
  logic [3:0]    rf_a3;
  logic [DW-1:0] rf_wd3;

  regfile_write_arbiter #(.DATAWIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .drop_r15(drop_r15)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [3:0]    a3;
    logic [DW-1:0] wd;
    logic          drop;
    logic          busy;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: clear index (-1 when not clearing), starvation
  // run length, and the last values seen on the write address/data lines.
  int          m_starve = 0;
  int          m_clr    = -1;
  logic [3:0]  m_a3     = '0;
  logic [DW-1:0] m_wd   = '0;
  int          p1_wins  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_starve = 0; m_clr = -1; m_a3 = '0; m_wd = '0;
    q.delete();
  endtask

  // One clock cycle: drive, check handshakes, predict next outputs
  task automatic step(input bit v0, input logic [3:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input logic [3:0] a1, input logic [DW-1:0] d1,
                      input bit clr);
    exp_t e;
    bit xr0, xr1, starving, g0, g1;
    logic [3:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    p0_valid = v0; p0_addr = a0; p0_data = d0;
    p1_valid = v1; p1_addr = a1; p1_data = d1;
    clr_start = clr;
    #1;
    e.drop = 1'b0;
    g0 = 1'b0; g1 = 1'b0;
    if (m_clr >= 0) begin
      xr0 = 1'b0; xr1 = 1'b0;
      if (m_clr < 14) begin
        m_clr++;
        e.we = 1'b1; e.a3 = 4'(m_clr); e.wd = '0; e.busy = 1'b1;
      end else begin
        m_clr = -1;
        e.we = 1'b0; e.a3 = m_a3; e.wd = m_wd; e.busy = 1'b0;
      end
    end else if (clr) begin
      xr0 = 1'b0; xr1 = 1'b0;
      m_starve = v1 ? ((m_starve >= 15) ? 15 : m_starve + 1) : 0;
      m_clr = 0;
      e.we = 1'b1; e.a3 = 4'd0; e.wd = '0; e.busy = 1'b1;
    end else begin
      starving = (m_starve >= LIMIT);
      xr0 = !(starving && v1);
      xr1 = !v0 || starving;
      if (v1 && (starving || !v0)) g1 = 1'b1;
      else if (v0) g0 = 1'b1;
      a = g1 ? a1 : a0;
      d = g1 ? d1 : d0;
      e.busy = 1'b0;
      if ((g0 || g1) && a != 4'd15) begin
        e.we = 1'b1; e.a3 = a; e.wd = d;
      end else begin
        e.we = 1'b0; e.a3 = m_a3; e.wd = m_wd;
        e.drop = (g0 || g1);
      end
      if (g1) p1_wins++;
      m_starve = (v1 && !g1) ? ((m_starve >= 15) ? 15 : m_starve + 1) : 0;
    end
    chk("p0_ready", DW'(p0_ready), DW'(xr0));
    chk("p1_ready", DW'(p1_ready), DW'(xr1));
    m_a3 = e.a3; m_wd = e.wd;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, '0, 0, 4'd0, '0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic mid_reset();
    #1;
    reset = 1'b0;
    p0_valid = 1'b0; p1_valid = 1'b0; clr_start = 1'b0;
    #1;
    chk("rst_rf_we", DW'(rf_we), '0);
    chk("rst_rf_a3", DW'(rf_a3), '0);
    chk("rst_rf_wd3", rf_wd3, '0);
    chk("rst_drop_r15", DW'(drop_r15), '0);
    chk("rst_clr_busy", DW'(clr_busy), '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("post_rst_p0_ready", DW'(p0_ready), 32'd1);
    chk("post_rst_p1_ready", DW'(p1_ready), 32'd1);
  endtask

  // Monitor: compares the DUT against the oldest prediction after each edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rf_we", DW'(rf_we), DW'(e.we));
      chk("rf_a3", DW'(rf_a3), DW'(e.a3));
      chk("rf_wd3", rf_wd3, e.wd);
      chk("drop_r15", DW'(drop_r15), DW'(e.drop));
      chk("clr_busy", DW'(clr_busy), DW'(e.busy));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wins_before;
    logic [3:0] ra0, ra1;
    // Power-on reset
    #3;
    chk("por_rf_we", DW'(rf_we), '0);
    chk("por_clr_busy", DW'(clr_busy), '0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("por_p0_ready", DW'(p0_ready), 32'd1);
    chk("por_p1_ready", DW'(p1_ready), 32'd1);

    // Single p0 write, idle cycle, second write, then reset mid-cycle
    step(1, 4'd3, 32'hDEADBEEF, 0, 4'd0, '0, 0);
    idle(1);
    step(1, 4'd9, 32'hCAFEF00D, 0, 4'd0, '0, 0);
    chk("pre_rst_rf_we", DW'(rf_we), 32'd1);
    mid_reset();

    // Contention: both held high, port 1 must win every LIMIT+1 edges
    wins_before = p1_wins;
    for (int i = 0; i < 2 * (LIMIT + 1); i++)
      step(1, 4'(i % 15), $urandom, 1, 4'd5, 32'h1000 + i, 0);
    chk("starve_p1_wins", DW'(p1_wins - wins_before), 32'd2);
    idle(1);

    // R15 reject from port 1
    step(0, 4'd0, '0, 1, 4'd15, 32'h1234, 0);
    idle(2);

    // Clear with pending p0, re-pulse at N+5, p0 lands after the sweep
    step(1, 4'd7, 32'hA5A5A5A5, 0, 4'd0, '0, 1);
    for (int i = 1; i <= 16; i++)
      step(1, 4'd7, 32'hA5A5A5A5, 0, 4'd0, '0, (i == 5));
    idle(2);

    // Reset mid-clear while address 7 is being written
    step(0, 4'd0, '0, 0, 4'd0, '0, 1);
    idle(7);
    chk("midclr_rf_a3", DW'(rf_a3), 32'd7);
    mid_reset();
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra0 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 1) == 1, ra0, $urandom,
           $urandom_range(0, 2) != 0, ra1, $urandom,
           $urandom_range(0, 39) == 0);
    end
    idle(18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
